// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width high windows separated by a
// mandatory low gap; pulses arriving mid-window are queued in a saturating counter.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int TMR_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic             gap_exit;
    logic             queue_evt;

    assign busy      = (state != S_IDLE);
    assign gap_exit  = (state == S_GAP) && (timer == '0);
    // Any pulse seen while a window or gap is running, except on the gap exit edge,
    // goes to the queue; the gap exit edge consumes it directly instead.
    assign queue_evt = pulse_in && busy && !gap_exit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            out      <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;

            if (queue_evt) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (pulse_in) begin
                        state <= S_HIGH;
                        timer <= HIGH_LOAD;
                        out   <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (timer == '0) begin
                        state <= S_GAP;
                        timer <= LOW_LOAD;
                        out   <= 1'b0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        if ((pending != '0) || pulse_in) begin
                            state <= S_HIGH;
                            timer <= HIGH_LOAD;
                            out   <= 1'b1;
                            // A fresh pulse on this edge cancels the dequeue.
                            if ((pending != '0) && !pulse_in) begin
                                pending <= pending - CNT_W'(1);
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a window-schedule reference model predicts
// each cycle's outputs, and an independent monitor compares them against the DUT.
module tb_pulse_stretcher;

    localparam int H     = 4;
    localparam int L     = 2;
    localparam int CW    = 2;
    localparam int MAXP  = (1 << CW) - 1;

    typedef struct {
        logic          out;
        logic          busy;
        logic [CW-1:0] pend;
        logic          ovf;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pulse_in;
    logic          out;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: first high cycle of the current window and queued pulse count.
    int m_start = -100;
    int m_pend  = 0;
    int m_ovf   = 0;
    int cyc     = 0;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .out     (out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req, input int c);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    // Drive one cycle's inputs (sampled at the next posedge) and predict the outputs
    // of the following cycle from the window schedule.
    task automatic step(input logic r, input logic p);
        int   last_gap;
        int   nxt;
        exp_t e;
        rst_n    = r;
        pulse_in = p;
        m_ovf    = 0;
        if (!r) begin
            m_start = -100;
            m_pend  = 0;
        end else begin
            last_gap = m_start + H + L - 1;
            if (cyc > last_gap) begin
                if (p) m_start = cyc + 1;
            end else if (cyc == last_gap) begin
                if (m_pend > 0 || p) begin
                    if (m_pend > 0 && !p) m_pend--;
                    m_start = cyc + 1;
                end
            end else if (p) begin
                if (m_pend < MAXP) m_pend++;
                else m_ovf = 1;
            end
        end
        nxt    = cyc + 1;
        e.out  = (nxt >= m_start) && (nxt < m_start + H);
        e.busy = (nxt >= m_start) && (nxt < m_start + H + L);
        e.pend = CW'(m_pend);
        e.ovf  = (m_ovf != 0);
        e.cyc  = nxt;
        exp_q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_seq(input logic [63:0] pulses, input logic [63:0] rsts_low, input int len);
        for (int i = 0; i < len; i++) begin
            step(!rsts_low[i], pulses[i]);
        end
    endtask

    // Monitor: the DUT presents a result every cycle; compare it once it has settled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out",      int'(out),      int'(e.out),  e.cyc);
                check("busy",     int'(busy),     int'(e.busy), e.cyc);
                check("pending",  int'(pending),  int'(e.pend), e.cyc);
                check("overflow", int'(overflow), int'(e.ovf),  e.cyc);
            end
        end
    end

    initial begin
        // Power-up: reset held two cycles while pulse_in toggles.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        // Single pulse.
        run_seq(64'h1, 64'h0, 10);
        // Three back-to-back pulses.
        run_seq(64'h7, 64'h0, 22);
        // Held six cycles: saturates the queue and overflows twice.
        run_seq(64'h3F, 64'h0, 30);
        // Pulse on the last gap cycle, pending=0 and then pending=1.
        run_seq(64'h41, 64'h0, 16);
        run_seq(64'h43, 64'h0, 22);
        // Reset mid-window while pulses arrive.
        run_seq(64'h7, 64'h4, 20);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 30));
        end
        run_seq(64'h0, 64'h0, 30);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
